sram_half_bridge: RTL

//  Physical-side controller between the LSU SRAM window (cs0 region) and the
//  off-chip 256Kx16 asynchronous SRAM. Converts one 32-bit word request (read,
//  or byte-masked write) into one or two 16-bit SRAM phases. Returns a single-

---
 rtl/sram_half_bridge_if.sv | 22 ++
 rtl/sram_half_bridge.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sram_half_bridge_if.sv
// LSU-side request/response bundle for the SRAM half-word bridge.
// The LSU is the master; the bridge is the slave.
interface sram_half_bridge_if;
  logic        i_req;
  logic        i_wren;
  logic [18:0] i_addr;
  logic [31:0] i_wdata;
  logic [3:0]  i_bmask;
  logic [31:0] o_rdata;
  logic        o_ack;
  logic        o_busy;

  modport master (
    output i_req, i_wren, i_addr, i_wdata, i_bmask,
    input  o_rdata, o_ack, o_busy
  );

  modport slave (
    input  i_req, i_wren, i_addr, i_wdata, i_bmask,
    output o_rdata, o_ack, o_busy
  );
endinterface

// File: rtl/sram_half_bridge.sv
// 32-bit LSU word access -> one or two 16-bit async SRAM phases (LO then HI).
// Every SRAM-facing output comes from a flop. The flop inputs are computed from
// the next state and next phase count, so the strobes line up with state_q.
module sram_half_bridge #(
  parameter int ACC_CYC = 2
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  sram_half_bridge_if.slave lsu,
  output logic [17:0]       o_sram_addr,
  inout  wire  [15:0]       io_sram_dq,
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n
);
  localparam int CW = $clog2(ACC_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACC_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wren_q, wren_d;
  logic [16:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    bmask_q, bmask_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ack_q, ack_d;
  logic          busy_q, busy_d;
  logic [17:0]   sram_addr_q, sram_addr_d;
  logic          ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic          lb_n_q, lb_n_d, ub_n_q, ub_n_d;
  logic          dq_oe_q, dq_oe_d;
  logic [15:0]   dq_out_q, dq_out_d;
  logic          hi_d;

  // The byte offset is irrelevant to a word access.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^lsu.i_addr[1:0];

  // Next state and phase counter. A request is latched only from IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wren_d  = wren_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    bmask_d = bmask_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (lsu.i_req) begin
          wren_d  = lsu.i_wren;
          addr_d  = lsu.i_addr[18:2];
          wdata_d = lsu.i_wdata;
          bmask_d = lsu.i_bmask;
          if (!lsu.i_wren || (|lsu.i_bmask[1:0])) state_d = S_LO;
          else if (|lsu.i_bmask[3:2])             state_d = S_HI;
          else                                    state_d = S_DONE;
        end
      end
      S_LO: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = (!wren_q || (|bmask_q[3:2])) ? S_HI : S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HI: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pre-compute the registered SRAM pins and the LSU response for the next cycle.
  always_comb begin
    hi_d        = (state_d == S_HI);
    ack_d       = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
    rdata_d     = rdata_q;
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    dq_oe_d     = 1'b0;
    ce_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    we_n_d      = 1'b1;
    lb_n_d      = 1'b1;
    ub_n_d      = 1'b1;
    // Read data is sampled on the last cycle of each phase.
    if (!wren_q && cnt_q == CNT_LAST) begin
      if (state_q == S_LO) rdata_d[15:0]  = io_sram_dq;
      if (state_q == S_HI) rdata_d[31:16] = io_sram_dq;
    end
    if (state_d == S_LO || state_d == S_HI) begin
      ce_n_d      = 1'b0;
      sram_addr_d = {addr_d, hi_d};
      if (wren_d) begin
        // we_n rises on the last cycle so data is held past the write edge.
        we_n_d   = (cnt_d == CNT_LAST);
        lb_n_d   = ~(hi_d ? bmask_d[2] : bmask_d[0]);
        ub_n_d   = ~(hi_d ? bmask_d[3] : bmask_d[1]);
        dq_oe_d  = 1'b1;
        dq_out_d = hi_d ? wdata_d[31:16] : wdata_d[15:0];
      end else begin
        oe_n_d = 1'b0;
        lb_n_d = 1'b0;
        ub_n_d = 1'b0;
      end
    end
  end

  // State, latched request and output registers. Reset drops every strobe at once.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wren_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      bmask_q     <= '0;
      rdata_q     <= '0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      sram_addr_q <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
      ub_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wren_q      <= wren_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      bmask_q     <= bmask_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      sram_addr_q <= sram_addr_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      lb_n_q      <= lb_n_d;
      ub_n_q      <= ub_n_d;
      dq_oe_q     <= dq_oe_d;
      dq_out_q    <= dq_out_d;
    end
  end

  assign lsu.o_rdata = rdata_q;
  assign lsu.o_ack   = ack_q;
  assign lsu.o_busy  = busy_q;
  assign o_sram_addr = sram_addr_q;
  assign o_sram_ce_n = ce_n_q;
  assign o_sram_oe_n = oe_n_q;
  assign o_sram_we_n = we_n_q;
  assign o_sram_lb_n = lb_n_q;
  assign o_sram_ub_n = ub_n_q;
  assign io_sram_dq  = dq_oe_q ? dq_out_q : 16'hzzzz;
endmodule
